// File: rtl/systolic_feeder.sv
// systolic_feeder
//   Front-end sequencer for an N x N signed systolic matrix-multiply array.
//   It collects operand matrices A and B one beat at a time: beat k carries
//   A row k and B column k. It then drives the array's row and column edges
//   with diagonally skewed, zero-padded streams, and pulses done once the
//   array's result matrix holds A x B.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   in_valid     load beat valid
//   in_ready     feeder accepts a load beat (high only while loading)
//   a_row[N]     beat k: A[k][0..N-1]
//   b_col[N]     beat k: B[0..N-1][k]
//   row_out[N]   registered stream to the array row inputs
//   col_out[N]   registered stream to the array column inputs
//   feed_active  high while the skewed streams are driven
//   done         one-cycle pulse; the array result is complete
module systolic_feeder #(
   parameter int WIDTH       = 16,
   parameter int N           = 3,
   parameter int MAC_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] a_row [N],
   input  logic signed [WIDTH-1:0] b_col [N],
   output logic signed [WIDTH-1:0] row_out [N],
   output logic signed [WIDTH-1:0] col_out [N],
   output logic                    feed_active,
   output logic                    done
);

   // The last product reaches PE[N-1][N-1] at t = 3N-3. The accumulated
   // result is visible MAC_LATENCY cycles later.
   localparam int T_DONE = 3*N - 3 + MAC_LATENCY;
   localparam int TW     = $clog2(T_DONE + 1);
   localparam int BW     = $clog2(N);

   localparam logic [TW-1:0] T_STREAM_END = TW'(2*N - 2);
   localparam logic [TW-1:0] T_DONE_V     = TW'(T_DONE);
   localparam logic [BW-1:0] BEAT_LAST    = BW'(N - 1);

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   beat_q,  beat_d;
   logic [TW-1:0]   t_q,     t_d;
   logic            accept;

   logic signed [WIDTH-1:0] a_q   [N][N];
   logic signed [WIDTH-1:0] b_q   [N][N];
   logic signed [WIDTH-1:0] row_q [N];
   logic signed [WIDTH-1:0] row_d [N];
   logic signed [WIDTH-1:0] col_q [N];
   logic signed [WIDTH-1:0] col_d [N];

   assign accept = in_valid && (state_q == ST_LOAD);

   // t counts from the first stream cycle through the done cycle. A single
   // counter therefore spans both STREAM and DRAIN.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      t_d     = t_q;
      case (state_q)
         ST_LOAD: begin
            if (accept) begin
               if (beat_q == BEAT_LAST) begin
                  state_d = ST_STREAM;
                  beat_d  = '0;
                  t_d     = '0;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         ST_STREAM: begin
            t_d = t_q + 1'b1;
            if (t_q == T_STREAM_END) begin
               // With zero drain length, go straight to DONE.
               state_d = (t_d == T_DONE_V) ? ST_DONE : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            t_d = t_q + 1'b1;
            if (t_d == T_DONE_V) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_LOAD;
            t_d     = '0;
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // Compute the lane values for the cycle being entered. This lets the
   // registered outputs show stream cycle t during cycle t.
   // Row lane i carries A[i][t-i]; column lane j carries B[t-j][j].
   always_comb begin
      for (int i = 0; i < N; i++) begin
         row_d[i] = '0;
         col_d[i] = '0;
      end
      if (state_d == ST_STREAM) begin
         for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
               if (int'(t_d) == i + k) begin
                  row_d[i] = a_q[i][k];
                  col_d[i] = b_q[k][i];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_LOAD;
         beat_q  <= '0;
         t_q     <= '0;
         for (int i = 0; i < N; i++) begin
            row_q[i] <= '0;
            col_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         t_q     <= t_d;
         for (int i = 0; i < N; i++) begin
            row_q[i] <= row_d[i];
            col_q[i] <= col_d[i];
         end
      end
   end

   // Operand storage is plain data and is not reset. A reset discards a
   // partial load by clearing the beat counter.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int r = 0; r < N; r++) begin
            if (int'(beat_q) == r) begin
               for (int c = 0; c < N; c++) begin
                  a_q[r][c] <= a_row[c];
                  b_q[c][r] <= b_col[c];
               end
            end
         end
      end
   end

   assign in_ready    = (state_q == ST_LOAD);
   assign feed_active = (state_q == ST_STREAM);
   assign done        = (state_q == ST_DONE);
   assign row_out     = row_q;
   assign col_out     = col_q;

endmodule
